// File: rtl/rvga_fetch_unit.sv
// rvga instruction fetch: pulls 128-bit lines into a single-line buffer and
// streams 32-bit words at the PC to decode, honouring branch redirects.

module rvga_fetch_unit_chk (
   input logic        clk,
   input logic        rst_n,
   input logic        mem_req,
   input logic [31:0] mem_addr,
   input logic        mem_gnt,
   input logic        inst_valid,
   input logic        inst_ready,
   input logic        redirect,
   input logic [31:0] inst,
   input logic [31:0] inst_pc
);
   // A request is either withdrawn or re-offered unchanged until accepted.
   a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (mem_req && !mem_gnt) |=> (!mem_req || $stable(mem_addr)));

   a_inst_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (inst_valid && !inst_ready && !redirect) |=>
         (inst_valid && $stable(inst) && $stable(inst_pc)));

   a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
      mem_addr[3:0] == 4'h0);
endmodule

module rvga_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0001_0054
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic         mem_req_o,
   output logic [31:0]  mem_addr_o,
   input  logic         mem_gnt_i,
   input  logic         mem_rvalid_i,
   input  logic [127:0] mem_rdata_i,
   input  logic         redirect_i,
   input  logic [31:0]  redirect_pc_i,
   output logic         inst_valid_o,
   output logic [31:0]  inst_o,
   output logic [31:0]  inst_pc_o,
   input  logic         inst_ready_i
);
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_SERVE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [31:0]   pc_r;
   logic [31:0]   pc_s;
   logic          discard_r;
   logic          discard_s;
   logic [127:0]  buf_r;
   logic [27:0]   tag_r;
   logic          buf_valid_r;
   logic          buf_load_s;
   logic          valid_s;
   logic [31:0]   inst_s;
   logic [31:0]   inst_pc_s;
   logic [31:0]   addr_s;
   logic          gnt_s;
   logic          hit_s;
   logic [31:0]   tgt_s;
   logic [31:0]   pc_inc_s;

   function automatic logic [31:0] word_sel(input logic [127:0] line,
                                            input logic [1:0]   idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         default: w = line[127:96];
      endcase
      return w;
   endfunction

   assign gnt_s    = mem_req_o & mem_gnt_i;
   assign tgt_s    = redirect_pc_i & 32'hFFFF_FFFC;
   assign hit_s    = buf_valid_r && (tgt_s[31:4] == tag_r);
   assign pc_inc_s = pc_r + 32'd4;

   // Next-state, next-PC and next registered-output computation.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      discard_s  = discard_r;
      buf_load_s = 1'b0;
      valid_s    = inst_valid_o;
      inst_s     = inst_o;
      inst_pc_s  = inst_pc_o;
      addr_s     = mem_addr_o;
      case (state_r)
         S_REQ: begin
            if (redirect_i) begin
               pc_s    = tgt_s;
               valid_s = 1'b0;
               if (gnt_s) begin
                  // Accepted request cannot be recalled; drop its line later.
                  state_s   = S_WAIT;
                  discard_s = 1'b1;
               end else if (hit_s) begin
                  state_s   = S_SERVE;
                  discard_s = 1'b0;
               end else if (mem_req_o) begin
                  discard_s = 1'b1;
               end else begin
                  addr_s = {tgt_s[31:4], 4'h0};
               end
            end else if (gnt_s) begin
               state_s = S_WAIT;
            end else if (!mem_req_o) begin
               addr_s = {pc_r[31:4], 4'h0};
            end else begin
               addr_s = mem_addr_o;
            end
         end
         S_WAIT: begin
            if (redirect_i) begin
               pc_s    = tgt_s;
               valid_s = 1'b0;
               if (mem_rvalid_i) begin
                  state_s   = S_REQ;
                  discard_s = 1'b0;
                  addr_s    = {tgt_s[31:4], 4'h0};
               end else begin
                  discard_s = 1'b1;
               end
            end else if (mem_rvalid_i) begin
               if (discard_r) begin
                  state_s   = S_REQ;
                  discard_s = 1'b0;
                  addr_s    = {pc_r[31:4], 4'h0};
               end else begin
                  buf_load_s = 1'b1;
                  state_s    = S_SERVE;
                  valid_s    = 1'b1;
                  inst_s     = word_sel(mem_rdata_i, pc_r[3:2]);
                  inst_pc_s  = pc_r;
               end
            end else begin
               state_s = S_WAIT;
            end
         end
         S_SERVE: begin
            if (redirect_i) begin
               pc_s    = tgt_s;
               valid_s = 1'b0;
               if (hit_s) begin
                  state_s = S_SERVE;
               end else begin
                  state_s = S_REQ;
                  addr_s  = {tgt_s[31:4], 4'h0};
               end
            end else if (!inst_valid_o) begin
               valid_s   = 1'b1;
               inst_s    = word_sel(buf_r, pc_r[3:2]);
               inst_pc_s = pc_r;
            end else if (inst_ready_i) begin
               pc_s = pc_inc_s;
               if (pc_inc_s[31:4] == tag_r) begin
                  valid_s   = 1'b1;
                  inst_s    = word_sel(buf_r, pc_inc_s[3:2]);
                  inst_pc_s = pc_inc_s;
               end else begin
                  valid_s = 1'b0;
                  state_s = S_REQ;
                  addr_s  = {pc_inc_s[31:4], 4'h0};
               end
            end else begin
               state_s = S_SERVE;
            end
         end
         default: begin
            state_s   = S_REQ;
            valid_s   = 1'b0;
            discard_s = 1'b0;
            addr_s    = {pc_r[31:4], 4'h0};
         end
      endcase
   end

   // State, line buffer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= S_REQ;
         pc_r         <= RESET_PC;
         discard_r    <= 1'b0;
         buf_r        <= 128'h0;
         tag_r        <= 28'h0;
         buf_valid_r  <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= 32'h0;
         inst_valid_o <= 1'b0;
         inst_o       <= 32'h0;
         inst_pc_o    <= 32'h0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         discard_r    <= discard_s;
         if (buf_load_s) begin
            buf_r       <= mem_rdata_i;
            tag_r       <= pc_r[31:4];
            buf_valid_r <= 1'b1;
         end
         mem_req_o    <= (state_s == S_REQ);
         mem_addr_o   <= addr_s;
         inst_valid_o <= valid_s;
         inst_o       <= inst_s;
         inst_pc_o    <= inst_pc_s;
      end
   end

   rvga_fetch_unit_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req_o),
      .mem_addr   (mem_addr_o),
      .mem_gnt    (mem_gnt_i),
      .inst_valid (inst_valid_o),
      .inst_ready (inst_ready_i),
      .redirect   (redirect_i),
      .inst       (inst_o),
      .inst_pc    (inst_pc_o)
   );
endmodule

// File: tb/tb_rvga_fetch_unit.sv
// Bench for rvga_fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model (pc sequence + memory contents).
module tb_rvga_fetch_unit;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         mem_req_o;
   logic [31:0]  mem_addr_o;
   logic         mem_gnt_i;
   logic         mem_rvalid_i;
   logic [127:0] mem_rdata_i;
   logic         redirect_i;
   logic [31:0]  redirect_pc_i;
   logic         inst_valid_o;
   logic [31:0]  inst_o;
   logic [31:0]  inst_pc_o;
   logic         inst_ready_i;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   rvga_fetch_unit #(.RESET_PC(32'h0001_0054)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_ready_i  (inst_ready_i)
   );

   // Instruction memory contents: a fixed line at 0x10050, hashed words elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (a[31:4] == 28'h000_1005) begin
         case (a[3:2])
            2'd0:    w = 32'h0000_0033;
            2'd1:    w = 32'h0000_0013;
            2'd2:    w = 32'h0000_0093;
            default: w = 32'h0000_006F;
         endcase
      end else begin
         w = ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      end
      return w;
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      logic [31:0] b;
      b = a & 32'hFFFF_FFF0;
      return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = 128'h0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      inst_ready_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) tick();
      cmp_cnt++;
      if ({mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o} !== 98'h0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got req=%b addr=%h v=%b inst=%h pc=%h, expected all zero",
                  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o);
      end
      rst_n = 1'b1;
      tick();
      cmp_cnt++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0001_0050}) begin
         err_cnt++;
         $display("FAIL first_req: got req=%b addr=%h, expected 1/00010050", mem_req_o, mem_addr_o);
      end
   endtask

   task automatic test_first_fetch();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      cmp_cnt++;
      if ({mem_req_o, inst_valid_o} !== 2'b00) begin
         err_cnt++;
         $display("FAIL after_grant: got req=%b v=%b, expected 0/0", mem_req_o, inst_valid_o);
      end
      tick();
      cmp_cnt++;
      if (inst_valid_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL wait_no_valid: got %b expected 0", inst_valid_o);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0001_0050);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 32'h0001_0054, 32'h0000_0013}) begin
         err_cnt++;
         $display("FAIL first_inst: got v=%b pc=%h inst=%h, expected 1/00010054/00000013",
                  inst_valid_o, inst_pc_o, inst_o);
      end
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 32'h0001_0058, 32'h0000_0093}) begin
         err_cnt++;
         $display("FAIL second_inst: got v=%b pc=%h inst=%h, expected 1/00010058/00000093",
                  inst_valid_o, inst_pc_o, inst_o);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         tick();
         cmp_cnt++;
         if ({inst_valid_o, inst_pc_o, inst_o, mem_req_o} !==
             {1'b1, 32'h0001_0058, 32'h0000_0093, 1'b0}) begin
            err_cnt++;
            $display("FAIL backpressure[%0d]: got v=%b pc=%h inst=%h req=%b, expected 1/00010058/00000093/0",
                     i, inst_valid_o, inst_pc_o, inst_o, mem_req_o);
         end
      end
   endtask

   task automatic test_redirect_hit();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0001_0050;
      tick();
      redirect_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o} !== 2'b00) begin
         err_cnt++;
         $display("FAIL hit_bubble: got v=%b req=%b, expected 0/0", inst_valid_o, mem_req_o);
      end
      tick();
      cmp_cnt++;
      if ({inst_valid_o, inst_pc_o, inst_o, mem_req_o} !==
          {1'b1, 32'h0001_0050, 32'h0000_0033, 1'b0}) begin
         err_cnt++;
         $display("FAIL hit_inst: got v=%b pc=%h inst=%h req=%b, expected 1/00010050/00000033/0",
                  inst_valid_o, inst_pc_o, inst_o, mem_req_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      inst_ready_i = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         exp_pc = 32'h0001_0050 + 32'(4 * i);
         cmp_cnt++;
         if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
            err_cnt++;
            $display("FAIL b2b[%0d]: got v=%b pc=%h inst=%h, expected 1/%h/%h",
                     i, inst_valid_o, inst_pc_o, inst_o, exp_pc, mem_word(exp_pc));
         end
      end
      tick();
      inst_ready_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h0001_0060}) begin
         err_cnt++;
         $display("FAIL line_cross: got v=%b req=%b addr=%h, expected 0/1/00010060",
                  inst_valid_o, mem_req_o, mem_addr_o);
      end
   endtask

   task automatic test_redirect_in_wait();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i     = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0002_0000;
      tick();
      redirect_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o} !== 2'b00) begin
         err_cnt++;
         $display("FAIL wait_redirect: got v=%b req=%b, expected 0/0", inst_valid_o, mem_req_o);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0001_0060);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h0002_0000}) begin
         err_cnt++;
         $display("FAIL stale_drop: got v=%b req=%b addr=%h, expected 0/1/00020000",
                  inst_valid_o, mem_req_o, mem_addr_o);
      end
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0002_0000);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 32'h0002_0000, mem_word(32'h0002_0000)}) begin
         err_cnt++;
         $display("FAIL target_inst: got v=%b pc=%h inst=%h, expected 1/00020000/%h",
                  inst_valid_o, inst_pc_o, inst_o, mem_word(32'h0002_0000));
      end
   endtask

   task automatic test_redirect_before_grant();
      inst_ready_i = 1'b1;
      repeat (4) tick();
      inst_ready_i  = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0003_0002;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h0002_0010}) begin
         err_cnt++;
         $display("FAIL cross_req: got v=%b req=%b addr=%h, expected 0/1/00020010",
                  inst_valid_o, mem_req_o, mem_addr_o);
      end
      tick();
      redirect_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmp_cnt++;
         if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0002_0010}) begin
            err_cnt++;
            $display("FAIL req_held[%0d]: got req=%b addr=%h, expected 1/00020010",
                     i, mem_req_o, mem_addr_o);
         end
         tick();
      end
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0002_0010);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h0003_0000}) begin
         err_cnt++;
         $display("FAIL discard_then_req: got v=%b req=%b addr=%h, expected 0/1/00030000",
                  inst_valid_o, mem_req_o, mem_addr_o);
      end
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0003_0000);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 32'h0003_0000, mem_word(32'h0003_0000)}) begin
         err_cnt++;
         $display("FAIL misaligned_target: got v=%b pc=%h inst=%h, expected 1/00030000/%h",
                  inst_valid_o, inst_pc_o, inst_o, mem_word(32'h0003_0000));
      end
   endtask

   task automatic test_reset_in_wait();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0004_0000;
      tick();
      redirect_i = 1'b0;
      mem_gnt_i  = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      cmp_cnt++;
      if ({mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o} !== 98'h0) begin
         err_cnt++;
         $display("FAIL async_reset: got req=%b addr=%h v=%b inst=%h pc=%h, expected all zero",
                  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o);
      end
      tick();
      #2 rst_n = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0004_0000);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h0001_0050}) begin
         err_cnt++;
         $display("FAIL late_resp: got v=%b req=%b addr=%h, expected 0/1/00010050",
                  inst_valid_o, mem_req_o, mem_addr_o);
      end
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_line(32'h0001_0050);
      tick();
      mem_rvalid_i = 1'b0;
      cmp_cnt++;
      if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, 32'h0001_0054, 32'h0000_0013}) begin
         err_cnt++;
         $display("FAIL refetch_inst: got v=%b pc=%h inst=%h, expected 1/00010054/00000013",
                  inst_valid_o, inst_pc_o, inst_o);
      end
   endtask

   // Random traffic: the delivered stream must follow pc+4 / redirect targets
   // with words taken from memory, whatever the grant/response timing.
   task automatic test_random();
      logic [31:0] mpc;
      logic [31:0] tgt;
      logic [31:0] pend_addr;
      logic [31:0] pv_pc;
      logic [31:0] pv_inst;
      logic [3:0]  rnd4;
      logic        rdy;
      logic        rdr;
      logic        pend;
      logic        hold_prev;
      int          lat;
      int          xfers;
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n     = 1'b1;
      mpc       = 32'h0001_0054;
      pend      = 1'b0;
      pend_addr = 32'h0;
      lat       = 0;
      hold_prev = 1'b0;
      pv_pc     = 32'h0;
      pv_inst   = 32'h0;
      xfers     = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold_prev) begin
            cmp_cnt++;
            if ({inst_valid_o, inst_pc_o, inst_o} !== {1'b1, pv_pc, pv_inst}) begin
               err_cnt++;
               $display("FAIL rand_hold@%0d: got v=%b pc=%h inst=%h, expected 1/%h/%h",
                        cyc, inst_valid_o, inst_pc_o, inst_o, pv_pc, pv_inst);
            end
         end
         rdy  = ($urandom_range(0, 3) != 0);
         rdr  = ($urandom_range(0, 15) == 0);
         rnd4 = 4'($urandom);
         case ($urandom_range(0, 3))
            0:       tgt = {mpc[31:4], rnd4};
            1:       tgt = 32'h0001_0000 + 32'($urandom_range(0, 255));
            2:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: tgt = $urandom;
         endcase
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = 128'h0;
         if (pend) begin
            if (lat == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem_line(pend_addr);
               pend         = 1'b0;
            end else begin
               lat--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
         end
         mem_gnt_i = ($urandom_range(0, 2) != 0);
         if (mem_req_o && mem_gnt_i) begin
            cmp_cnt++;
            if (pend || (mem_addr_o[3:0] !== 4'h0)) begin
               err_cnt++;
               $display("FAIL rand_req@%0d: got outstanding=%b addr=%h, expected 0/line-aligned",
                        cyc, pend, mem_addr_o);
            end
            pend      = 1'b1;
            pend_addr = mem_addr_o;
            lat       = $urandom_range(0, 2);
         end
         if (inst_valid_o && rdy) begin
            cmp_cnt++;
            if ({inst_pc_o, inst_o} !== {mpc, mem_word(mpc)}) begin
               err_cnt++;
               $display("FAIL rand_stream@%0d: got pc=%h inst=%h, expected %h/%h",
                        cyc, inst_pc_o, inst_o, mpc, mem_word(mpc));
            end
            mpc = mpc + 32'd4;
            xfers++;
         end
         if (rdr) begin
            mpc = tgt & 32'hFFFF_FFFC;
         end
         hold_prev     = inst_valid_o && !rdy && !rdr;
         pv_pc         = inst_pc_o;
         pv_inst       = inst_o;
         inst_ready_i  = rdy;
         redirect_i    = rdr;
         redirect_pc_i = tgt;
         tick();
      end
      idle_inputs();
      cmp_cnt++;
      if (xfers < 100) begin
         err_cnt++;
         $display("FAIL rand_progress: got %0d transfers, expected at least 100", xfers);
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_redirect_hit();
      test_back_to_back();
      test_redirect_in_wait();
      test_redirect_before_grant();
      test_reset_in_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
